// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pkg
// Purpose  : Shared types and constant helpers for the parameterised IEEE-754
//            multiplier: rounding-mode enum and encodings of the bias,
//            canonical quiet NaN and largest finite magnitude.
// Revision : 1.0  initial release
// ============================================================================
package fp_mul_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,   // round to nearest, ties to even
        RTZ = 2'b01,   // round toward zero
        RUP = 2'b10,   // round toward +inf
        RDN = 2'b11    // round toward -inf
    } rnd_e;

    // Encodings below are built in a 64-bit container and truncated by the user.
    localparam int c_FIELD_W = 64;

    function automatic int bias(input int expo_w);
        return (1 << (expo_w - 1)) - 1;
    endfunction

    // Canonical qNaN: sign 0, all-ones exponent, only the fraction MSB set.
    function automatic logic [c_FIELD_W-1:0] qnan(input int expo_w, input int mant_w);
        logic [c_FIELD_W-1:0] v;
        v = ((64'd1 << expo_w) - 64'd1) << mant_w;
        v = v | (64'd1 << (mant_w - 1));
        return v;
    endfunction

    // Largest finite magnitude (sign bit excluded).
    function automatic logic [c_FIELD_W-1:0] max_finite(input int expo_w, input int mant_w);
        logic [c_FIELD_W-1:0] v;
        v = ((64'd1 << expo_w) - 64'd2) << mant_w;
        v = v | ((64'd1 << mant_w) - 64'd1);
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_lzc
// Purpose  : Parameterised leading-zero counter used to normalise products of
//            subnormal operands.
// Ports    : i_data  [WIDTH-1:0]  vector to scan from the MSB
//            o_count [CNT_W-1:0]  number of leading zeros (WIDTH when all zero)
// Revision : 1.0  initial release
// ============================================================================
module fp_mul_lzc #(
    parameter int WIDTH = 48,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    // Ascending scan: the highest set bit is visited last and wins.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_para.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_para
// Purpose  : Parameterised IEEE-754 binary multiplier, res = round(a * b),
//            combinational datapath followed by one output register.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset, clears res
//            a, b   operands {sign, expo, mant}
//            rnd    rounding mode (RNE, RTZ, toward +inf, toward -inf)
//            res    registered rounded product, one cycle after a/b/rnd
// Revision : 1.0  initial release
// ============================================================================
module fp_mul_para
    import fp_mul_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  a,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  b,
    input  logic [1:0]                       rnd,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0]  res
);

    localparam int c_W   = SIGN_W + EXPO_W + MANT_W;
    localparam int c_P   = MANT_W + 1;          // significand incl. hidden bit
    localparam int c_PW  = 2 * c_P;             // full product width
    localparam int c_EW  = EXPO_W + 2;          // signed working exponent
    localparam int c_LZW = $clog2(c_PW + 1);

    localparam logic [c_EW-1:0] c_BIAS    = c_EW'(bias(EXPO_W));
    localparam logic [c_EW-1:0] c_EXP_INF = c_EW'((1 << EXPO_W) - 1);
    localparam logic [c_W-1:0]  c_QNAN    = c_W'(qnan(EXPO_W, MANT_W));
    localparam logic [c_W-2:0]  c_MAX_FIN = (c_W - 1)'(max_finite(EXPO_W, MANT_W));
    localparam logic [c_W-2:0]  c_INF_MAG = {{EXPO_W{1'b1}}, {MANT_W{1'b0}}};

    // ---------------- unpack / classify ----------------
    logic                w_sa, w_sb, w_sign;
    logic [EXPO_W-1:0]   w_ea, w_eb;
    logic [MANT_W-1:0]   w_ma, w_mb;
    logic                w_ea_zero, w_eb_zero, w_ea_max, w_eb_max;
    logic                w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic                w_nan, w_inf_in, w_zero_in;

    assign w_sa      = a[c_W-1];
    assign w_sb      = b[c_W-1];
    assign w_ea      = a[MANT_W +: EXPO_W];
    assign w_eb      = b[MANT_W +: EXPO_W];
    assign w_ma      = a[MANT_W-1:0];
    assign w_mb      = b[MANT_W-1:0];
    assign w_sign    = w_sa ^ w_sb;
    assign w_ea_zero = ~|w_ea;
    assign w_eb_zero = ~|w_eb;
    assign w_ea_max  = &w_ea;
    assign w_eb_max  = &w_eb;
    assign w_a_zero  = w_ea_zero & ~|w_ma;
    assign w_b_zero  = w_eb_zero & ~|w_mb;
    assign w_a_inf   = w_ea_max & ~|w_ma;
    assign w_b_inf   = w_eb_max & ~|w_mb;
    assign w_a_nan   = w_ea_max & |w_ma;
    assign w_b_nan   = w_eb_max & |w_mb;
    assign w_nan     = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
    assign w_inf_in  = w_a_inf | w_b_inf;
    assign w_zero_in = w_a_zero | w_b_zero;

    // ---------------- multiply ----------------
    logic [c_P-1:0]  w_sig_a, w_sig_b;
    logic [c_EW-1:0] w_exp_a, w_exp_b;
    logic [c_PW-1:0] w_prod;

    // Subnormals carry a zero hidden bit and an effective exponent of 1.
    assign w_sig_a = {~w_ea_zero, w_ma};
    assign w_sig_b = {~w_eb_zero, w_mb};
    assign w_exp_a = w_ea_zero ? c_EW'(1) : {2'b00, w_ea};
    assign w_exp_b = w_eb_zero ? c_EW'(1) : {2'b00, w_eb};
    assign w_prod  = {{c_P{1'b0}}, w_sig_a} * {{c_P{1'b0}}, w_sig_b};

    // ---------------- normalise / subnormal shift ----------------
    logic [c_LZW-1:0] w_lz;
    logic [c_EW-1:0]  w_exp_n, w_exp_r, w_sh;
    logic [c_PW-1:0]  w_prod_n, w_prod_s;
    logic             w_under, w_lost;

    fp_mul_lzc #(
        .WIDTH (c_PW),
        .CNT_W (c_LZW)
    ) u_lzc (
        .i_data  (w_prod),
        .o_count (w_lz)
    );

    // A product MSB in the top bit means 1.x * 2^(ea+eb-2*bias+1); each
    // leading zero removed from the product lowers that exponent by one.
    assign w_exp_n  = w_exp_a + w_exp_b - c_BIAS + c_EW'(1) - c_EW'(w_lz);
    assign w_prod_n = w_prod << w_lz;

    // Exponent <= 0: shift into the subnormal range at exponent field 0.
    assign w_under  = w_exp_n[c_EW-1] | (w_exp_n == '0);
    assign w_sh     = w_under ? (c_EW'(1) - w_exp_n) : '0;
    assign w_lost   = |(w_prod_n & ~({c_PW{1'b1}} << w_sh));
    assign w_prod_s = w_prod_n >> w_sh;
    assign w_exp_r  = w_under ? '0 : w_exp_n;

    // ---------------- round ----------------
    logic [c_P-1:0]  w_keep;
    logic            w_guard, w_sticky, w_inc;
    logic [c_P:0]    w_sum;
    logic [c_EW-1:0] w_exp_f;
    logic [MANT_W-1:0] w_frac_f;
    logic            w_ovf;
    logic [c_W-2:0]  w_ovf_mag;
    logic [c_W-1:0]  w_res;
    logic [c_W-1:0]  r_res;

    assign w_keep   = w_prod_s[c_PW-1 -: c_P];
    assign w_guard  = w_prod_s[MANT_W];
    assign w_sticky = (|w_prod_s[MANT_W-1:0]) | w_lost;

    always_comb begin
        w_inc = 1'b0;
        case (rnd_e'(rnd))
            RNE:     w_inc = w_guard & (w_sticky | w_keep[0]);
            RTZ:     w_inc = 1'b0;
            RUP:     w_inc = ~w_sign & (w_guard | w_sticky);
            RDN:     w_inc = w_sign & (w_guard | w_sticky);
            default: w_inc = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_keep} + (c_P + 1)'(w_inc);

    // Carry out of a normal significand bumps the exponent; a subnormal that
    // rounds up into the hidden position becomes the minimum normal.
    assign w_exp_f  = (w_exp_r == '0) ? c_EW'(w_sum[MANT_W]) : (w_exp_r + c_EW'(w_sum[c_P]));
    assign w_frac_f = w_sum[c_P] ? w_sum[MANT_W:1] : w_sum[MANT_W-1:0];
    assign w_ovf    = (w_exp_f >= c_EXP_INF);

    always_comb begin
        w_ovf_mag = c_INF_MAG;
        case (rnd_e'(rnd))
            RNE:     w_ovf_mag = c_INF_MAG;
            RTZ:     w_ovf_mag = c_MAX_FIN;
            RUP:     w_ovf_mag = w_sign ? c_MAX_FIN : c_INF_MAG;
            RDN:     w_ovf_mag = w_sign ? c_INF_MAG : c_MAX_FIN;
            default: w_ovf_mag = c_INF_MAG;
        endcase
    end

    // ---------------- special-case mux ----------------
    always_comb begin
        w_res = {w_sign, w_exp_f[EXPO_W-1:0], w_frac_f};
        if (w_nan) begin
            w_res = c_QNAN;
        end else if (w_inf_in) begin
            w_res = {w_sign, c_INF_MAG};
        end else if (w_zero_in) begin
            w_res = {w_sign, {(c_W-1){1'b0}}};
        end else if (w_ovf) begin
            w_res = {w_sign, w_ovf_mag};
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else begin
            r_res <= w_res;
        end
    end

    assign res = r_res;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_para.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_para
// Purpose  : Self-checking bench for fp_mul_para (fp32) against an exact
//            integer value-domain reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_mul_para;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b, res;
    logic [1:0]  rnd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  r;
        logic [31:0] e;
    } vec_t;

    fp_mul_para #(
        .SIGN_W (1),
        .EXPO_W (8),
        .MANT_W (23)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .rnd   (rnd),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact reference: product as integer times a power of two, then rounded
    // to the quantum of the destination binade (or the subnormal quantum).
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] mode);
        logic        s, up, above, tie, inexact;
        logic [63:0] sx, sy, p, qm, rem, half;
        int          ex, ey, n, e0, bexp, q, d, expo;
        logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        s      = x[31] ^ y[31];
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        x_zero = (x[30:0] == 0);
        y_zero = (y[30:0] == 0);
        if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf)) return 32'h7FC00000;
        if (x_inf || y_inf) return {s, 8'hFF, 23'd0};
        if (x_zero || y_zero) return {s, 31'd0};
        ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
        sx = {40'd0, x[30:23] != 0, x[22:0]};
        sy = {40'd0, y[30:23] != 0, y[22:0]};
        p  = sx * sy;
        n  = 0;
        for (int i = 0; i < 64; i++) if (p[i]) n = i;
        e0   = ex + ey - 254 - 46;       // value = p * 2^e0
        bexp = n + e0 + 127;
        q    = (bexp < 1) ? -149 : bexp - 150;
        d    = q - e0;
        above = 1'b0; tie = 1'b0; inexact = 1'b0;
        if (d <= 0) begin
            qm = p << (-d);
        end else if (d >= 60) begin
            qm = 64'd0;
            inexact = 1'b1;
        end else begin
            qm      = p >> d;
            rem     = p & ((64'd1 << d) - 64'd1);
            half    = 64'd1 << (d - 1);
            above   = rem > half;
            tie     = rem == half;
            inexact = rem != 0;
        end
        case (mode)
            2'b00:   up = above || (tie && qm[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = inexact && !s;
            default: up = inexact && s;
        endcase
        qm = qm + {63'd0, up};
        if (qm == (64'd1 << 24)) begin
            qm = 64'd1 << 23;
            q  = q + 1;
        end
        expo = (qm >= (64'd1 << 23)) ? q + 150 : 0;
        if (expo >= 255) begin
            case (mode)
                2'b00:   return {s, 8'hFF, 23'd0};
                2'b01:   return {s, 31'h7F7FFFFF};
                2'b10:   return s ? 32'hFF7FFFFF : 32'h7F800000;
                default: return s ? 32'hFF800000 : 32'h7F7FFFFF;
            endcase
        end
        return {s, 8'(expo), qm[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:       v[30:0] = 31'd0;
            1:       v[30:0] = {8'hFF, 23'd0};
            2:       begin v[30:23] = 8'hFF; if (v[22:0] == 0) v[0] = 1'b1; end
            3:       v[30:23] = 8'd0;
            4:       v[30:23] = 8'($urandom_range(1, 4));
            5:       v[30:23] = 8'($urandom_range(250, 254));
            6, 7:    v[30:23] = 8'($urandom_range(100, 154));
            8:       v[22:0] = v[0] ? 23'h7FFFFF : 23'd0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a = 32'h40000000; b = 32'h40400000; rnd = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", res, 32'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        vecs.push_back({32'h3F800000, 32'h3F800000, 2'b00, 32'h3F800000});
        vecs.push_back({32'h40000000, 32'hC0400000, 2'b00, 32'hC0C00000});
        vecs.push_back({32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000});
        vecs.push_back({32'h80000000, 32'h3F800000, 2'b00, 32'h80000000});
        vecs.push_back({32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000});
        vecs.push_back({32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF});
        vecs.push_back({32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F800000});
        vecs.push_back({32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F7FFFFF});
        vecs.push_back({32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF7FFFFF});
        vecs.push_back({32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002});
        vecs.push_back({32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002});
        vecs.push_back({32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003});
        vecs.push_back({32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002});
        vecs.push_back({32'h00800000, 32'h3F000000, 2'b00, 32'h00400000});
        vecs.push_back({32'h00000001, 32'h3F000000, 2'b00, 32'h00000000});
        vecs.push_back({32'h00000001, 32'h3F000000, 2'b10, 32'h00000001});
        vecs.push_back({32'h00000001, 32'hBF000000, 2'b11, 32'h80000001});
        vecs.push_back({32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000});
        vecs.push_back({32'hFF800000, 32'hBF800000, 2'b00, 32'h7F800000});
        vecs.push_back({32'h00000000, 32'hFF800000, 2'b00, 32'h7FC00000});
        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; rnd = vecs[i].r;
            @(negedge clk);
            checks++;
            if (res !== vecs[i].e) begin
                errors++;
                $display("FAIL directed[%0d] a=%h b=%h rnd=%0d got=%h want=%h",
                         i, vecs[i].a, vecs[i].b, vecs[i].r, res, vecs[i].e);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_v;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            a = rand_op(); b = rand_op(); rnd = 2'($urandom_range(0, 3));
            exp_v = ref_mul(a, b, rnd);
            @(negedge clk);
            checks++;
            if (res !== exp_v) begin
                errors++;
                $display("FAIL random a=%h b=%h rnd=%0d got=%h want=%h", a, b, rnd, res, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] exp_v;
        for (int i = 0; i <= 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (res !== exp_v) begin
                    errors++;
                    $display("FAIL back_to_back[%0d] got=%h want=%h", i, res, exp_v);
                end
            end
            if (i < 3000) begin
                a = rand_op(); b = rand_op(); rnd = 2'($urandom_range(0, 3));
                exp_q.push_back(ref_mul(a, b, rnd));
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a = 32'h40000000; b = 32'h40400000; rnd = 2'b00;
        @(posedge clk);
        #2;
        checks++;
        if (res !== 32'h40C00000) begin
            errors++;
            $display("FAIL pre_reset got=%h want=%h", res, 32'h40C00000);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", res, 32'h0);
        end
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h40000000;
        @(negedge clk);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL reset_held got=%h want=%h", res, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (res !== 32'h40400000) begin
            errors++;
            $display("FAIL post_release got=%h want=%h", res, 32'h40400000);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
